// File: rtl/counter_updown_mod_if.sv
// -----------------------------------------------------------------------------
// counter_updown_mod_if
// Control/status bundle for one counter_updown_mod stage.
//   master : drives enable, load, load_value, mode; observes counter, dir, tc, wrap
//   slave  : the counter itself (opposite directions)
// Signals:
//   enable      count enable
//   load        synchronous parallel load (priority over enable)
//   load_value  value applied on load (N bits)
//   mode        00 up, 01 down, 10 hold, 11 ping-pong
//   counter     registered count value (N bits)
//   dir         registered ping-pong direction (0 up, 1 down)
//   tc          combinational terminal-count flag
//   wrap        registered one-cycle wrap / turn-around pulse
// -----------------------------------------------------------------------------
interface counter_updown_mod_if #(
  parameter int N = 3
);
  logic         enable;
  logic         load;
  logic [N-1:0] load_value;
  logic [1:0]   mode;
  logic [N-1:0] counter;
  logic         dir;
  logic         tc;
  logic         wrap;

  modport master (
    output enable, load, load_value, mode,
    input  counter, dir, tc, wrap
  );

  modport slave (
    input  enable, load, load_value, mode,
    output counter, dir, tc, wrap
  );
endinterface

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
// Parametrised N-bit modulo counter (sequence 0..MOD-1) with count enable,
// synchronous clamped parallel load, up/down/hold direction and an optional
// ping-pong (triangle) mode. Provides a combinational terminal-count flag (tc)
// for cascading and a registered one-cycle wrap pulse.
//
// Compile-time option: define COUNTER_PINGPONG_EN to make mode 11 a ping-pong
// counter with a direction register. Without it, mode 11 behaves as mode 00
// and dir is tied to 0.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset
//   bus    slave modport of counter_updown_mod_if (enable, load, load_value,
//          mode in; counter, dir, tc, wrap out)
// Parameters:
//   N    counter width, 1..32
//   modulus parameter (MOD), 2..2**N, defaults to 2**N
// -----------------------------------------------------------------------------
module counter_updown_mod #(
  parameter int     N   = 3,
  parameter longint MOD = 64'sd1 << N
) (
  input  logic                    clock,
  input  logic                    reset,
  counter_updown_mod_if.slave     bus
);

  // Elaboration-time legality checks
  if (N < 32'sd1 || N > 32'sd32) begin : g_bad_n
    $error("counter_updown_mod: N out of range 1..32");
  end
  if (MOD < 64'sd2 || MOD > (64'sd1 << N)) begin : g_bad_mod
    $error("counter_updown_mod: MOD out of range 2..2**N");
  end

  // All next-state arithmetic is one bit wider so MOD = 2**N never truncates.
  localparam logic [N:0] LAST = (N+1)'(MOD - 64'sd1);
  localparam logic [N:0] ONE  = (N+1)'(1);
  localparam logic [N:0] ZERO = (N+1)'(0);

  logic [N-1:0] counter_q, counter_d;
  logic         wrap_q, wrap_d;
  logic         dir_s;
  logic         tc_s;
  logic [N:0]   cnt_ext_s;
  logic [N:0]   inc_s;
  logic [N:0]   dec_s;
  logic [N:0]   lv_ext_s;
  logic         at_last_s;
  logic         at_zero_s;

`ifdef COUNTER_PINGPONG_EN
  logic         dir_q, dir_d;
  logic [N:0]   pp_turn_dn_s;
  assign dir_s        = dir_q;
  assign pp_turn_dn_s = LAST - ONE;
`else
  assign dir_s = 1'b0;
`endif

  assign cnt_ext_s = {1'b0, counter_q};
  assign lv_ext_s  = {1'b0, bus.load_value};
  assign inc_s     = cnt_ext_s + ONE;
  assign dec_s     = cnt_ext_s - ONE;
  assign at_last_s = (cnt_ext_s == LAST);
  assign at_zero_s = (cnt_ext_s == ZERO);

  // Next-state selection: load > enabled step > hold
  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
`ifdef COUNTER_PINGPONG_EN
    dir_d     = dir_q;
`endif
    if (bus.load) begin
      // Out-of-range load values clamp to the top of the sequence.
      if (lv_ext_s > LAST) begin
        counter_d = LAST[N-1:0];
      end else begin
        counter_d = bus.load_value;
      end
    end else if (bus.enable) begin
      case (bus.mode)
        2'b00: begin
          if (at_last_s) begin
            counter_d = ZERO[N-1:0];
            wrap_d    = 1'b1;
          end else begin
            counter_d = inc_s[N-1:0];
          end
        end
        2'b01: begin
          if (at_zero_s) begin
            counter_d = LAST[N-1:0];
            wrap_d    = 1'b1;
          end else begin
            counter_d = dec_s[N-1:0];
          end
        end
        2'b11: begin
`ifdef COUNTER_PINGPONG_EN
          if (!dir_q) begin
            if (at_last_s) begin
              counter_d = pp_turn_dn_s[N-1:0];
              dir_d     = 1'b1;
              wrap_d    = 1'b1;
            end else begin
              counter_d = inc_s[N-1:0];
            end
          end else begin
            if (at_zero_s) begin
              counter_d = ONE[N-1:0];
              dir_d     = 1'b0;
              wrap_d    = 1'b1;
            end else begin
              counter_d = dec_s[N-1:0];
            end
          end
`else
          // Without ping-pong support mode 11 is a plain up counter.
          if (at_last_s) begin
            counter_d = ZERO[N-1:0];
            wrap_d    = 1'b1;
          end else begin
            counter_d = inc_s[N-1:0];
          end
`endif
        end
        default: begin
          counter_d = counter_q;
          wrap_d    = 1'b0;
        end
      endcase
    end else begin
      counter_d = counter_q;
      wrap_d    = 1'b0;
    end
  end

  // Terminal count: high when the next enabled edge will wrap or turn around
  always_comb begin
    tc_s = 1'b0;
    case (bus.mode)
      2'b00:   tc_s = bus.enable && at_last_s;
      2'b01:   tc_s = bus.enable && at_zero_s;
`ifdef COUNTER_PINGPONG_EN
      2'b11:   tc_s = bus.enable && (dir_s ? at_zero_s : at_last_s);
`else
      2'b11:   tc_s = bus.enable && at_last_s;
`endif
      default: tc_s = 1'b0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      counter_q <= '0;
      wrap_q    <= 1'b0;
`ifdef COUNTER_PINGPONG_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
`ifdef COUNTER_PINGPONG_EN
      dir_q     <= dir_d;
`endif
    end
  end

  assign bus.counter = counter_q;
  assign bus.wrap    = wrap_q;
  assign bus.dir     = dir_s;
  assign bus.tc      = tc_s;

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised N-bit modulo counter: the next generation of the free-running 3-bit counter used in the lab display and timing designs. It adds a configurable width and modulus, count enable, synchronous parallel load, and selectable up/down/hold direction. It also provides a terminal-count flag and a registered wrap pulse for cascading counters, for example seconds/minutes chains and display multiplexing. An optional ping-pong (triangle) mode can be compiled in.

## Interface
- N, default 3: counter width in bits; legal range 1..32.
- MOD, default 2**N: modulus; counter sequence is 0..MOD-1. Legal range 2..2**N; elaboration error outside it.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count enable; when low, the count holds.
- load  in  1  synchronous parallel load; takes priority over enable.
- load_value  in  N  value applied on load.
- mode  in  2  00 = up, 01 = down, 10 = hold, 11 = ping-pong (see Configuration).
- counter  out  N  registered count value.
- dir  out  1  registered ping-pong direction: 0 = up, 1 = down. Always 0 when ping-pong is not compiled in.
- tc  out  1  combinational terminal-count flag.
- wrap  out  1  registered one-cycle pulse, high in the cycle after a wrap or turn-around.

## Operation
- Priority per rising edge: reset > load > (enable && mode) > hold.
- Reset:
  - counter = 0, dir = 0, wrap = 0.
  - tc then follows its combinational rule from counter = 0 and the current mode.
- Load:
  - counter <= load_value, clamped to MOD-1 if load_value >= MOD.
  - wrap <= 0; dir unchanged.
  - enable is ignored in the same cycle.
- Up (mode 00, enable = 1):
  - counter == MOD-1: counter <= 0, wrap <= 1.
  - Otherwise: counter <= counter + 1, wrap <= 0.
- Down (mode 01, enable = 1):
  - counter == 0: counter <= MOD-1, wrap <= 1.
  - Otherwise: counter <= counter - 1, wrap <= 0.
- Hold (mode 10), or enable = 0 in any mode:
  - counter and dir unchanged, wrap <= 0.
- Ping-pong (mode 11, enable = 1, macro defined):
  - dir = 0 and counter == MOD-1: counter <= MOD-2, dir <= 1, wrap <= 1.
  - dir = 1 and counter == 0: counter <= 1, dir <= 0, wrap <= 1.
  - Otherwise: step by +1 (dir = 0) or -1 (dir = 1), wrap <= 0.
  - If MOD == 2, the turn-around alternates 0,1,0,1…
- Arithmetic:
  - All next-state arithmetic is N+1 bits wide, with compares against MOD-1 at N+1 bits, so MOD = 2**N is handled without truncation.
  - counter never holds a value >= MOD.
- Mode changes take effect on the next enabled edge; no intermediate state is created.
- A mode change away from ping-pong leaves dir unchanged. dir is cleared only by reset.

## Timing
- Latency from an enabled edge to the updated counter is one clock.
- wrap is asserted for exactly one cycle, aligned with the first cycle in which counter shows the wrapped value.
- tc is combinational from counter, dir, mode and enable, with no register stage:
  - mode 00: enable && counter == MOD-1.
  - mode 01: enable && counter == 0.
  - mode 11: enable && ((!dir && counter == MOD-1) || (dir && counter == 0)).
  - mode 10: 0.
- Cascade rule: the next stage's enable = tc of this stage. The next stage then advances on the same edge that this stage wraps.
- Reset asserted mid-count takes effect on the next edge regardless of load or enable. Outputs are valid from the first edge after reset.

## Configuration
- Macro COUNTER_PINGPONG_EN.
- Defined: mode 11 is ping-pong as specified above; the dir register exists.
- Undefined:
  - mode 11 behaves exactly as mode 00 (up), including tc and wrap.
  - dir is tied to 0; no direction register is synthesised.

## Test plan
- Reset/up wrap (N = 3, MOD = 6): reset, then enable with mode 00 for 7 cycles.
  - counter goes 0,1,2,3,4,5,0,1.
  - tc is high while counter = 5.
  - wrap is high only in the cycle showing the first 0 after 5.
- Down wrap and load clamp (N = 3, MOD = 6):
  - load 7 -> counter = 5, wrap = 0.
  - Then mode 01 for 6 cycles -> 4,3,2,1,0,5; wrap pulses on the 5.
- Priority and hold:
  - load = 1 and enable = 1 with load_value = 2 -> counter = 2, not 3.
  - enable = 0 for 3 cycles -> counter stays 2, tc = 0.
  - reset together with load -> counter = 0.
- Ping-pong (macro defined, N = 3, MOD = 4): mode 11 for 8 cycles from 0.
  - counter goes 1,2,3,2,1,0,1,2.
  - dir rises when counter goes 3 -> 2 and falls when 0 -> 1.
  - wrap pulses at both turn-arounds.
- Cascade and full range:
  - Two instances (N = 4, MOD = 10), with the high stage's enable driven by the low stage's tc.
  - After 25 enabled cycles from reset: high = 2, low = 5.
  - Separately, N = 3 with MOD = 8 wraps 7 -> 0.
- Macro undefined: mode 11 from counter = 6 (N = 3, MOD = 8) gives 7, then 0 with wrap; dir stays 0 throughout.
